// File: rtl/matrix_column_assembler.sv
// Collects N column beats (K elements each) into a row-major K x N buffer and hands the whole matrix on with valid/ready.
// Optional framing check on col_last / frame_err is enabled by defining MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN.
module matrix_column_assembler #(
    parameter int K          = 6,
    parameter int N          = 6,
    parameter int DATA_WIDTH = 16,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         col_valid,
    output logic                         col_ready,
    input  logic [K*DATA_WIDTH-1:0]      col_data,
`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
    input  logic                         col_last,
    output logic                         frame_err,
`endif
    output logic                         mat_valid,
    input  logic                         mat_ready,
    output logic [K*N*DATA_WIDTH-1:0]    matrix_flat,
    output logic [IDX_W-1:0]             col_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   last_col;

    assign accept   = col_valid && col_ready;
    assign last_col = (col_idx == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        col_ready = 1'b0;
        mat_valid = 1'b0;
        case (state_q)
            FILL: begin
                col_ready = 1'b1;
                if (col_valid && last_col) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                mat_valid = 1'b1;
                if (mat_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Column write: element r of the beat lands in row r, column col_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_flat <= '0;
            col_idx     <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                matrix_flat[(r*N + int'(col_idx))*DATA_WIDTH +: DATA_WIDTH]
                    <= col_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
            col_idx <= last_col ? '0 : col_idx + 1'b1;
        end
    end

`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
    // Sticky: only reset clears it; the FSM keeps counting regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (accept && (col_last != last_col)) begin
            frame_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_column_assembler.sv
// Directed bench for matrix_column_assembler: a K=2,N=3 instance for the main scenarios and a default 6x6 instance for streaming.
// Framing checks are compiled in when MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN is defined.
module tb_matrix_column_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         cv, cr, mv, mr;
    logic [31:0]  cd;
    logic [95:0]  flat;
    logic [1:0]   cidx;

    logic         cv6, cr6, mv6, mr6;
    logic [95:0]  cd6;
    logic [575:0] flat6;
    logic [2:0]   cidx6;

`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
    logic cl, cl6, fe, fe6, cl_ovr, cl_val;
    assign cl  = cl_ovr ? cl_val : (cidx == 2'd2);
    assign cl6 = (cidx6 == 3'd5);
`endif

    int n_cmp = 0;
    int n_bad = 0;

    matrix_column_assembler #(.K(2), .N(3), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .col_valid(cv), .col_ready(cr), .col_data(cd),
`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
        .col_last(cl), .frame_err(fe),
`endif
        .mat_valid(mv), .mat_ready(mr), .matrix_flat(flat), .col_idx(cidx)
    );

    matrix_column_assembler dut6 (
        .clk(clk), .rst_n(rst_n), .col_valid(cv6), .col_ready(cr6), .col_data(cd6),
`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
        .col_last(cl6), .frame_err(fe6),
`endif
        .mat_valid(mv6), .mat_ready(mr6), .matrix_flat(flat6), .col_idx(cidx6)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cv = 1'b0; cd = '0; mr = 1'b1;
        cv6 = 1'b0; cd6 = '0; mr6 = 1'b1;
`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
        cl_ovr = 1'b0; cl_val = 1'b0;
`endif
        #12;
        chk("rst_idx", cidx, 0);
        chk("rst_mv", mv, 0);
        chk("rst_flat", flat, 0);
        chk("rst_cr", cr, 1);
        rst_n = 1'b1;
        step();

        // Basic fill, back-to-back with mat_ready high
        cv = 1'b1;
        cd = {16'h0004, 16'h0001}; step();
        chk("fill_idx1", cidx, 1);
        cd = {16'h0005, 16'h0002}; step();
        chk("fill_idx2", cidx, 2);
        chk("fill_mv_early", mv, 0);
        cd = {16'h0006, 16'h0003}; step();
        cv = 1'b0;
        chk("fill_mv", mv, 1);
        chk("fill_cr_low", cr, 0);
        chk("fill_idx_wrap", cidx, 0);
        chk("fill_flat", flat, 96'h0006_0005_0004_0003_0002_0001);
        step();
        chk("fill_mv_done", mv, 0);
        chk("fill_cr_back", cr, 1);

        // Back-pressure: hold for 10 cycles with col_valid stuck high
        mr = 1'b0;
        cv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cd = {16'(16'h20 + c), 16'(16'h10 + c)};
            step();
        end
        cd = {16'hDEAD, 16'hBEEF};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_mv%0d", i), mv, 1);
            chk($sformatf("bp_cr%0d", i), cr, 0);
            chk($sformatf("bp_flat%0d", i), flat, 96'h0022_0021_0020_0012_0011_0010);
            step();
        end
        cv = 1'b0;
        mr = 1'b1;
        step();
        chk("bp_release_mv", mv, 0);
        chk("bp_release_idx", cidx, 0);
        chk("bp_release_flat", flat, 96'h0022_0021_0020_0012_0011_0010);
        chk("bp_release_cr", cr, 1);

        // Input gaps: valid pattern 1,0,0,1,0,1
        begin
            logic [5:0] pat;
            logic [1:0] exp_idx [6];
            int wc;
            pat = 6'b101001;
            exp_idx = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
            wc = 0;
            for (int i = 0; i < 6; i++) begin
                cv = pat[i];
                cd = pat[i] ? {16'(16'h40 + wc), 16'(16'h30 + wc)} : {16'hFFFF, 16'hFFFF};
                if (pat[i]) wc++;
                step();
                chk($sformatf("gap_idx%0d", i), cidx, exp_idx[i]);
                chk($sformatf("gap_mv%0d", i), mv, (i == 5) ? 1 : 0);
            end
        end
        cv = 1'b0;
        chk("gap_flat", flat, 96'h0042_0041_0040_0032_0031_0030);
        step();
        chk("gap_done_mv", mv, 0);

        // Reset mid-fill, asserted between edges
        cv = 1'b1;
        cd = {16'h0A0A, 16'h0B0B}; step();
        cd = {16'h0C0C, 16'h0D0D}; step();
        chk("midrst_pre_idx", cidx, 2);
        cv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mv", mv, 0);
        chk("midrst_idx", cidx, 0);
        chk("midrst_flat", flat, 0);
        rst_n = 1'b1;
        step();
        chk("midrst_no_emit", mv, 0);
        cv = 1'b1;
        cd = {16'h0104, 16'h0101}; step();
        cd = {16'h0105, 16'h0102}; step();
        cd = {16'h0106, 16'h0103}; step();
        cv = 1'b0;
        chk("midrst_clean_mv", mv, 1);
        chk("midrst_clean_flat", flat, 96'h0106_0105_0104_0103_0102_0101);
        step();
        chk("midrst_clean_done", mv, 0);

`ifdef MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN
        // Framing: col_last asserted on the 2nd beat
        chk("fe_clean", fe, 0);
        cl_ovr = 1'b1;
        cv = 1'b1;
        cl_val = 1'b0; cd = {16'h0001, 16'h0001}; step();
        chk("fe_beat1", fe, 0);
        cl_val = 1'b1; cd = {16'h0002, 16'h0002}; step();
        chk("fe_beat2", fe, 1);
        cl_val = 1'b1; cd = {16'h0003, 16'h0003}; step();
        cv = 1'b0;
        cl_ovr = 1'b0;
        chk("fe_mv", mv, 1);
        chk("fe_flat", flat, 96'h0003_0002_0001_0003_0002_0001);
        step();
        chk("fe_sticky", fe, 1);
        chk("fe6_clean", fe6, 0);
`endif

        // Two back-to-back 6x6 matrices, counting values in column-major order
        for (int m = 0; m < 2; m++) begin
            int base;
            base = (m == 0) ? 0 : 100;
            cv6 = 1'b1;
            for (int c = 0; c < 6; c++) begin
                for (int r = 0; r < 6; r++) cd6[r*16 +: 16] = 16'(base + c*6 + r);
                step();
            end
            chk($sformatf("m%0d_mv", m), mv6, 1);
            chk($sformatf("m%0d_cr", m), cr6, 0);
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    chk($sformatf("m%0d_r%0dc%0d", m, r, c), flat6[(r*6+c)*16 +: 16], 16'(base + c*6 + r));
            if (m == 0) begin
                // Next matrix's first column is offered during the handshake cycle but must not be taken
                for (int r = 0; r < 6; r++) cd6[r*16 +: 16] = 16'(100 + r);
                step();
                chk("bubble_mv", mv6, 0);
                chk("bubble_idx", cidx6, 0);
                chk("bubble_cr", cr6, 1);
            end else begin
                cv6 = 1'b0;
                step();
                chk("m1_done_mv", mv6, 0);
                chk("m1_done_idx", cidx6, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_column_assembler.md
Name: matrix_column_assembler

Overview:
- Streaming inverse of the column-major extraction path.
- Accepts an N-column matrix one column per valid/ready beat (column-major order, e.g. systolic-array result columns) and writes each element into a row-major register buffer.
- After N columns it presents the full K×N matrix as a row-major flat bus with valid/ready, then re-arms.
- Sits between the array's column drain and downstream row-major consumers (memory writer, next-stage A operand).

Parameters:
- K, 6, rows per column (elements per input beat)
- N, 6, columns per matrix (beats per matrix)
- DATA_WIDTH, 16, bits per element

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- col_valid  input  1  column beat valid
- col_ready  output  1  block can accept a column
- col_data  input  K*DATA_WIDTH  one column; element r at bits [(r+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- mat_valid  output  1  full matrix available
- mat_ready  input  1  consumer accepts matrix
- matrix_flat  output  K*N*DATA_WIDTH  row-major; element [r][c] at bits [((r*N+c)+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- col_idx  output  max(1,$clog2(N))  index of next column to be written

Behaviour:
- Clock/reset: one clock domain; reset is asynchronous, active-low (rst_n), clock is clk.
- Reset values: state=FILL, col_idx=0, mat_valid=0, buffer (matrix_flat)=0, col_ready=1 once rst_n deasserted.
- FSM states:
  - FILL: col_ready=1, mat_valid=0.
  - HOLD: col_ready=0, mat_valid=1.
- FILL transfer: when col_valid && col_ready, col_data element r is written to buffer[r][col_idx] at the clock edge.
  - col_idx < N-1: col_idx increments.
  - col_idx == N-1: col_idx wraps to 0 and state becomes HOLD.
- FILL with col_valid=0: no change.
- HOLD: matrix_flat is stable; mat_valid stays high until mat_valid && mat_ready; next state FILL.
  - col_valid is ignored while in HOLD (col_ready=0, no write).
- Latency: mat_valid rises the cycle after the Nth accepted column. After the output handshake, col_ready returns the next cycle. This is one bubble cycle per matrix and is intentional: no input/output overlap.
- Buffer is not cleared between matrices; every element is overwritten during FILL.
- matrix_flat during FILL shows the partially overwritten buffer. Consumers sample only on mat_valid.
- Registered outputs: col_ready, mat_valid, matrix_flat and col_idx are registered or derived only from registered state; no combinational path from inputs to outputs.
- Degenerate sizes:
  - N=1: every accepted beat goes straight to HOLD.
  - K=1: each beat is one element.
- Reset mid-operation (any state, any col_idx): immediately returns to reset values. A partially collected matrix is discarded and never emitted.
- Back-pressure: mat_ready held low indefinitely keeps HOLD and data stable; no overflow possible.

Optional Feature:
- Macro: MATRIX_COLUMN_ASSEMBLER_LAST_CHECK_EN.
- Defined:
  - Adds input col_last (1 bit, qualifies the beat) and output frame_err (1 bit, sticky, reset 0).
  - frame_err is set if an accepted beat has col_last=1 with col_idx != N-1, or col_last=0 with col_idx == N-1.
  - The FSM still advances purely on count; frame_err clears only on reset.
- Undefined: neither port exists; framing is purely by count.

Test Plan (K=2, N=3, DATA_WIDTH=16 unless noted):
- Basic fill: from reset, send columns {0x0001,0x0004}, {0x0002,0x0005}, {0x0003,0x0006} back-to-back with mat_ready=1 → mat_valid high one cycle after the 3rd beat; matrix_flat row-major = 1,2,3,4,5,6 (element0=1 at LSBs); col_ready low that cycle, high again next cycle.
- Back-pressure: complete a matrix with mat_ready=0 for 10 cycles, col_valid=1 throughout → col_ready=0, matrix_flat unchanged, no extra writes; raise mat_ready → one handshake, then FILL with col_idx=0.
- Gaps in input: col_valid toggled 1,0,0,1,0,1 → exactly 3 writes, col_idx sequence 0→1→1→1→2→2→0, mat_valid after the third write only.
- Reset mid-fill: accept 2 columns, pulse rst_n low asynchronously (between edges) → mat_valid=0, col_idx=0, matrix_flat=0 immediately; the next 3 columns produce a clean matrix.
- Back-to-back matrices, default K=N=6: stream two matrices of counting values 0..35 and 100..135 (column-major order) → two mat_valid handshakes with correct row-major values and exactly one bubble cycle between them.
- LAST_CHECK_EN defined: send col_last=1 on the 2nd beat → frame_err=1 next cycle and stays 1; matrix still emitted after the 3rd beat.
